spi_rx_axis: RTL
================

# spi_rx_axis

Parametrised serial receiver converting the ASIC's SPI-like output (sclk, multi-lane sdata, svalid) into an AXI4-Stream master with buffering and backpressure. Replaces the single-lane fixed-32-bit receiver: the serial inputs are oversampled in the aclk domain, so there is no separate sclk clock domain. Words are assembled, queued in an internal FIFO, and emitted with tlast framing. FIFO overflow is reported instead of passing silently.

## Interface
- DATA_W, 32: word width; must be a multiple of LANES.
- LANES, 1: number of sdata lanes; allowed values 1, 2, 4.
- FIFO_DEPTH, 8: word FIFO depth; power of two, ≥2.
- FRAME_LEN, 4: words per frame; tlast asserts on the FRAME_LEN-th word.
- aclk  in  1  AXI bus clock; must be ≥4× the sclk frequency.
- aresetn  in  1  reset; asynchronous, active-low.
- sclk  in  1  serial clock from the ASIC; asynchronous, sampled in aclk.
- sdata  in  LANES  serial data; bit [LANES-1] is the most significant.
- svalid  in  1  serial burst valid.
- m_axis_tdata  out  DATA_W  word data.
- m_axis_tvalid  out  1  word valid.
- m_axis_tlast  out  1  end of frame or end of burst.
- m_axis_tready  in  1  downstream ready.
- overflow  out  1  sticky; set when a word is dropped because the FIFO is full.
- overflow_cnt  out  16  saturating count of dropped words.

## Operation
- sclk, sdata and svalid each pass through a 2-FF synchroniser. A falling edge of synchronised sclk is a *beat*.
- Assembler states: IDLE and SHIFT.
- IDLE:
  - On a beat with svalid=1: shift reg = {0, sdata}, beat count = 1, go to SHIFT.
  - On a beat with svalid=0: nothing happens.
- SHIFT, beat with svalid=1:
  - shift reg = {shift reg[DATA_W-LANES-1:0], sdata}; beat count +1.
  - On reaching DATA_W/LANES beats: push the word with tlast = (frame count == FRAME_LEN-1); beat count = 0; stay in SHIFT.
- SHIFT, beat with svalid=0 (burst end):
  - If beat count > 0: push the partial word right-aligned, upper bits zero, tlast=1.
  - If beat count == 0 (burst ended exactly on a word boundary): set tlast on the next push is not required; the last full word already carries its computed tlast.
  - In both cases: frame count = 0, go to IDLE.
- Frame count increments on every push attempt, whether accepted or dropped. It wraps to 0 after FRAME_LEN and also resets on burst end.
- Push while FIFO is full and no pop in the same cycle: word dropped, overflow=1, overflow_cnt +1 (saturates at 0xFFFF).
- Push and pop in the same cycle when full: both accepted, nothing dropped.
- FIFO stores {tlast, data}. The output is registered, first-word-fall-through.

## Timing
- Reset values: m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, overflow=0, overflow_cnt=0. FIFO, assembler, beat count and frame count are cleared; state=IDLE.
- Reset mid-word discards the partial word and emits nothing.
- Beat detect: 3 aclk cycles after the sclk falling edge reaches the pins (2 sync stages + edge register).
- Push occurs in the cycle after the completing beat is detected.
- m_axis_tvalid rises 1 cycle after a push into an empty FIFO.
- Sustained throughput: 1 word per cycle when tready=1.
- AXI-Stream rules:
  - Transfer happens when tvalid && tready.
  - While tvalid && !tready, tdata and tlast are held stable and tvalid stays high.
  - tvalid never depends combinationally on tready.
- overflow clears only on reset.

## Configuration
- SPI_RX_OVF_CNT_EN defined: overflow_cnt is implemented as specified.
- SPI_RX_OVF_CNT_EN undefined: the counter is not built and overflow_cnt is tied to 0. The sticky overflow flag is present in both builds.

## Test plan
- LANES=1, DATA_W=32: one burst of 32 beats carrying 0xDEADBEEF, tready=1 -> one transfer, tdata=0xDEADBEEF, tlast=0.
- LANES=1, FRAME_LEN=4: 8 words 0x1..0x8 sent back-to-back -> tlast=1 only on 0x4 and 0x8.
- LANES=4: 5-word burst followed by 3 extra beats with sdata=0xA, 0xB, 0xC, then svalid low -> 6th word is 0x00000ABC with tlast=1; frame count restarts for the next burst.
- FIFO_DEPTH=8, tready=0, 10 words pushed -> 8 stored, overflow=1, overflow_cnt=2. With tready=1 afterwards, the first 8 words drain in order.
- tready toggled randomly during a 16-word stream -> no loss, no duplication, tdata/tlast stable while stalled.
- aresetn pulsed low after 12 beats of a word -> all outputs at reset values, no word emitted; the next full burst is received correctly.

Source files
------------

// File: rtl/spi_rx_axis_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : spi_rx_axis_if
// Brief    : AXI4-Stream word channel carrying tdata/tlast with handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_rx_axis_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/spi_rx_axis.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : spi_rx_axis
// Brief    : Oversampled multi-lane serial receiver feeding a framed AXI4-Stream
//            master through a word FIFO. Define SPI_RX_OVF_CNT_EN to build the
//            dropped-word counter; otherwise overflow_cnt reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module spi_rx_axis #(
  parameter int DATA_W     = 32,
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_LEN  = 4
) (
  input  wire logic             aclk,
  input  wire logic             aresetn,
  input  wire logic             sclk,
  input  wire logic [LANES-1:0] sdata,
  input  wire logic             svalid,
  spi_rx_axis_if.master         m_axis,
  output logic                  overflow,
  output logic [15:0]           overflow_cnt
);

  localparam int c_BEATS  = DATA_W / LANES;
  localparam int c_BCNT_W = $clog2(c_BEATS + 1);
  localparam int c_FCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Synchroniser, edge detect and beat-aligned data
  logic [1:0]       r_sclk_sync;
  logic [1:0]       r_svalid_sync;
  logic [LANES-1:0] r_sdata_s1;
  logic [LANES-1:0] r_sdata_s2;
  logic             r_sclk_prev;
  logic             r_beat;
  logic             r_beat_valid;
  logic [LANES-1:0] r_beat_data;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sclk_sync   <= '0;
      r_svalid_sync <= '0;
      r_sdata_s1    <= '0;
      r_sdata_s2    <= '0;
      r_sclk_prev   <= 1'b0;
      r_beat        <= 1'b0;
      r_beat_valid  <= 1'b0;
      r_beat_data   <= '0;
    end else begin
      r_sclk_sync   <= {r_sclk_sync[0], sclk};
      r_svalid_sync <= {r_svalid_sync[0], svalid};
      r_sdata_s1    <= sdata;
      r_sdata_s2    <= r_sdata_s1;
      r_sclk_prev   <= r_sclk_sync[1];
      r_beat        <= r_sclk_prev & ~r_sclk_sync[1];
      r_beat_valid  <= r_svalid_sync[1];
      r_beat_data   <= r_sdata_s2;
    end
  end

  // Word assembler
  state_t              r_state;
  logic [DATA_W-1:0]   r_shift;
  logic [c_BCNT_W-1:0] r_beat_cnt;
  logic [c_FCNT_W-1:0] r_frame_cnt;
  logic                r_push;
  logic [DATA_W-1:0]   r_push_data;
  logic                r_push_last;
  logic [DATA_W-1:0]   w_shift_next;
  logic [c_BCNT_W-1:0] w_cnt_next;
  logic                w_word_open;

  always_comb begin
    w_word_open  = (r_state == ST_SHIFT) && (r_beat_cnt != '0);
    w_shift_next = ((w_word_open ? r_shift : '0) << LANES) | DATA_W'(r_beat_data);
    w_cnt_next   = (w_word_open ? r_beat_cnt : '0) + c_BCNT_W'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_beat_cnt  <= '0;
      r_frame_cnt <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_push_last <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (r_beat) begin
        if (r_beat_valid) begin
          r_state <= ST_SHIFT;
          if (w_cnt_next == c_BCNT_W'(c_BEATS)) begin
            r_push      <= 1'b1;
            r_push_data <= w_shift_next;
            r_push_last <= (r_frame_cnt == c_FCNT_W'(FRAME_LEN - 1));
            r_frame_cnt <= (r_frame_cnt == c_FCNT_W'(FRAME_LEN - 1)) ? '0
                                                                     : r_frame_cnt + c_FCNT_W'(1);
            r_beat_cnt  <= '0;
            r_shift     <= '0;
          end else begin
            r_shift    <= w_shift_next;
            r_beat_cnt <= w_cnt_next;
          end
        end else if (r_state == ST_SHIFT) begin
          // Burst end: flush any partial word right-aligned and close the frame
          if (r_beat_cnt != '0) begin
            r_push      <= 1'b1;
            r_push_data <= r_shift;
            r_push_last <= 1'b1;
          end
          r_frame_cnt <= '0;
          r_beat_cnt  <= '0;
          r_shift     <= '0;
          r_state     <= ST_IDLE;
        end
      end
    end
  end

  // Word FIFO; capacity counts the word held in the output register
  logic [DATA_W:0]    r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [DATA_W-1:0]  r_tdata;
  logic               r_tvalid;
  logic               r_tlast;
  logic               r_overflow;
  logic               w_pop;
  logic               w_out_free;
  logic               w_full;
  logic               w_accept;
  logic               w_drop;
  logic               w_mem_rd;
  logic               w_mem_wr;
  logic               w_bypass;

  always_comb begin
    w_pop      = r_tvalid & m_axis.tready;
    w_out_free = ~r_tvalid | m_axis.tready;
    w_full     = (r_count + c_CNT_W'(r_tvalid)) == c_CNT_W'(FIFO_DEPTH);
    w_accept   = r_push & (~w_full | w_pop);
    w_drop     = r_push & ~w_accept;
    w_mem_rd   = w_out_free & (r_count != '0);
    w_bypass   = w_out_free & (r_count == '0) & w_accept;
    w_mem_wr   = w_accept & ~w_bypass;
  end

  always_ff @(posedge aclk) begin
    if (w_mem_wr) begin
      r_mem[r_wr_ptr] <= {r_push_last, r_push_data};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_mem_rd) begin
        {r_tlast, r_tdata} <= r_mem[r_rd_ptr];
        r_tvalid           <= 1'b1;
        r_rd_ptr           <= r_rd_ptr + c_PTR_W'(1);
      end else if (w_bypass) begin
        r_tdata  <= r_push_data;
        r_tlast  <= r_push_last;
        r_tvalid <= 1'b1;
      end else if (w_out_free) begin
        r_tvalid <= 1'b0;
      end
      if (w_mem_wr) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      case ({w_mem_wr, w_mem_rd})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = r_tlast;
  assign overflow      = r_overflow;

`ifdef SPI_RX_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign overflow_cnt = r_ovf_cnt;
`else
  assign overflow_cnt = 16'd0;
`endif

endmodule
`default_nettype wire
